sobel_frame_ctrl: RTL and testbench

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_frame_ctrl_if.sv | 37 +++
 rtl/sobel_xy_cnt.sv | 57 +++++
 rtl/sobel_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame controller.
// Holds the FSM state enum, dimension/counter/pixel widths and the frame size helper.
package sobel_pkg;

  localparam int DIM_W = 11;
  localparam int CNT_W = 22;
  localparam int PIX_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Pixels per frame. Both dimensions are widened before the multiply
  // so the 11x11 product never truncates.
  function automatic logic [CNT_W-1:0] frame_px(
    input logic [DIM_W-1:0] w,
    input logic [DIM_W-1:0] h
  );
    return CNT_W'(w) * CNT_W'(h);
  endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Stream bundle between pixel source, Sobel datapath and its output monitor.
// master: source/sink side (testbench or fabric); slave: the frame controller.
interface sobel_frame_ctrl_if;
  import sobel_pkg::*;

  logic [PIX_W-1:0] src_data;
  logic             src_valid;
  logic             src_ready;
  logic [PIX_W-1:0] dst_data;
  logic             dst_valid;
  logic             dst_ready;
  logic             mon_valid;
  logic             mon_ready;

  modport master (
    output src_data,
    output src_valid,
    output dst_ready,
    output mon_valid,
    output mon_ready,
    input  src_ready,
    input  dst_data,
    input  dst_valid
  );

  modport slave (
    input  src_data,
    input  src_valid,
    input  dst_ready,
    input  mon_valid,
    input  mon_ready,
    output src_ready,
    output dst_data,
    output dst_valid
  );

endinterface

// File: rtl/sobel_xy_cnt.sv
// Column/row raster counter for one frame.
// Ports: clk, rst_n (sync, active-low), clear, advance, width, height -> col, row, last.
module sobel_xy_cnt
  import sobel_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic             last
);

  logic [DIM_W-1:0] col_q;
  logic [DIM_W-1:0] col_d;
  logic [DIM_W-1:0] row_q;
  logic [DIM_W-1:0] row_d;
  logic             col_end;
  logic             row_end;

  assign col_end = (col_q == width - DIM_W'(1));
  assign row_end = (row_q == height - DIM_W'(1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller in front of a Sobel datapath: shadows config, gates the pixel
// stream for exactly one frame, counts datapath outputs and reports frame status.
// Ports: clk, rst_n (sync, active-low); cfg_start/width/height/threshold in;
// threshold, busy, frame_done, cfg_err, timeout_err out; bus (src/dst/mon streams).
// Optional: SOBEL_FRAME_CTRL_TIMEOUT_EN compiles in the DRAIN watchdog
// (limit TIMEOUT_CYCLES); without it timeout_err is tied low.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [7:0]       cfg_threshold,
  output logic [7:0]       threshold,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err,
  output logic             timeout_err,
  sobel_frame_ctrl_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic [DIM_W-1:0] w_q;
  logic [DIM_W-1:0] h_q;
  logic [7:0]       thr_q;
  logic [CNT_W-1:0] out_q;
  logic [CNT_W-1:0] out_d;
  logic [CNT_W-1:0] total;
  logic             cfg_err_q;
  logic             run;
  logic             in_hs;
  logic             mon_hs;
  logic             start;
  logic             zero_start;
  logic             out_full;
  logic             wd_fire;
  logic             last;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;
  logic             unused_xy;

  // Gating with rst_n closes the stream in the reset cycle itself.
  assign run = (state_q == RUN) && rst_n;

  assign bus.dst_data  = bus.src_data;
  assign bus.dst_valid = run && bus.src_valid;
  assign bus.src_ready = run && bus.dst_ready;

  assign in_hs  = bus.src_valid && bus.src_ready;
  assign mon_hs = bus.mon_valid && bus.mon_ready
               && ((state_q == RUN) || (state_q == DRAIN));

  assign start      = (state_q == IDLE) && cfg_start
                   && (cfg_width != '0) && (cfg_height != '0);
  assign zero_start = (state_q == IDLE) && cfg_start
                   && ((cfg_width == '0) || (cfg_height == '0));

  assign total = frame_px(w_q, h_q);
  assign out_d = start ? '0 : out_q + CNT_W'(mon_hs);

  // Count is complete either already or with this cycle's handshake.
  assign out_full = (out_q == total) || (out_d == total);

  sobel_xy_cnt u_xy (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .advance (in_hs),
    .width   (w_q),
    .height  (h_q),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  assign unused_xy = ^{col, row};

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic            to_q;
  logic            to_d;

  assign wd_fire = (state_q == DRAIN) && !mon_hs && !out_full
                && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = '0;
    if ((state_q == DRAIN) && !mon_hs && !wd_fire)
      wd_d = wd_q + WD_W'(1);
  end

  // Sticky until the next accepted start.
  assign to_d = start ? 1'b0 : (to_q || wd_fire);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign timeout_err = to_q;
`else
  logic unused_to;

  assign unused_to   = (TIMEOUT_CYCLES != 0);
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (in_hs && last) state_d = DRAIN;
      DRAIN: begin
        if (out_full)     state_d = DONE;
        else if (wd_fire) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q       <= '0;
      h_q       <= '0;
      thr_q     <= '0;
      out_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      if (start) begin
        w_q   <= cfg_width;
        h_q   <= cfg_height;
        thr_q <= cfg_threshold;
      end
      out_q     <= out_d;
      cfg_err_q <= zero_start;
    end
  end

  assign threshold  = thr_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl: directed frames push expected pixels
// and frame_done thresholds; a negedge monitor pops and compares.
module tb_sobel_frame_ctrl;
  import sobel_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic [DIM_W-1:0] cfg_width = '0;
  logic [DIM_W-1:0] cfg_height = '0;
  logic [7:0]       cfg_threshold = '0;
  logic [7:0]       threshold;
  logic             busy;
  logic             frame_done;
  logic             cfg_err;
  logic             timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PIX_W-1:0] exp_pix[$];
  logic [7:0]       exp_done[$];
  logic [PIX_W-1:0] mon_e;
  logic [7:0]       mon_t;

  sobel_frame_ctrl_if bus();

  sobel_frame_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .cfg_threshold (cfg_threshold),
    .threshold     (threshold),
    .busy          (busy),
    .frame_done    (frame_done),
    .cfg_err       (cfg_err),
    .timeout_err   (timeout_err),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL sim_timeout bench did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] pix(input int f, input int i);
    return {8'(f), 8'(i), 8'(8'hA5 ^ (i * 37))};
  endfunction

  task automatic drv(input logic sv, input logic [PIX_W-1:0] d,
                     input logic dr, input logic mv);
    bus.src_valid = sv;
    bus.src_data  = d;
    bus.dst_ready = dr;
    bus.mon_valid = mv;
    bus.mon_ready = mv;
  endtask

  task automatic start(input int w, input int h, input int thr);
    cfg_start     = 1'b1;
    cfg_width     = DIM_W'(w);
    cfg_height    = DIM_W'(h);
    cfg_threshold = 8'(thr);
    cyc();
    cfg_start = 1'b0;
  endtask

  // n pixels at full rate; the first mon_n cycles also echo a mon handshake.
  task automatic feed(input int f, input int n, input int mon_n,
                      input int thr);
    for (int i = 0; i < n; i++) begin
      drv(1'b1, pix(f, i), 1'b1, i < mon_n);
      exp_pix.push_back(pix(f, i));
      mid();
      chk("src_ready_run", 32'(bus.src_ready), 1);
      chk("thr_run", 32'(threshold), 32'(thr));
      cyc();
    end
  endtask

  always @(negedge clk) begin
    if (bus.dst_valid && bus.dst_ready) begin
      n_tests++;
      if (exp_pix.size() == 0) begin
        n_fail++;
        $display("FAIL pix_extra got=%h exp=none", bus.dst_data);
      end else begin
        mon_e = exp_pix.pop_front();
        if (bus.dst_data !== mon_e) begin
          n_fail++;
          $display("FAIL pix_data got=%h exp=%h", bus.dst_data, mon_e);
        end
      end
    end
    if (frame_done) begin
      n_tests++;
      if (exp_done.size() == 0) begin
        n_fail++;
        $display("FAIL done_extra got=1 exp=0");
      end else begin
        mon_t = exp_done.pop_front();
        if (threshold !== mon_t) begin
          n_fail++;
          $display("FAIL done_thr got=%0d exp=%0d", threshold, mon_t);
        end
      end
    end
  end

  initial begin
    int idx;
    int cnt;
    logic dr;
    logic [0:5] mpat;

    drv(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cyc();
    mid();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_to_err", 32'(timeout_err), 0);
    chk("rst_thr", 32'(threshold), 0);
    chk("rst_src_ready", 32'(bus.src_ready), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Full-speed 4x2 frame, mon echoes every pixel in the same cycle.
    exp_done.push_back(8'd60);
    start(4, 2, 60);
    mid();
    chk("f1_busy", 32'(busy), 1);
    cyc();
    feed(1, 8, 8, 60);
    drv(1'b1, 24'hDEAD01, 1'b1, 1'b0);
    mid();
    chk("f1_drain_src_ready", 32'(bus.src_ready), 0);
    chk("f1_drain_dst_valid", 32'(bus.dst_valid), 0);
    chk("f1_drain_busy", 32'(busy), 1);
    chk("f1_drain_done", 32'(frame_done), 0);
    cyc();
    drv(1'b0, '0, 1'b0, 1'b0);
    mid();
    chk("f1_done", 32'(frame_done), 1);
    chk("f1_done_thr", 32'(threshold), 60);
    cyc();
    mid();
    chk("f1_idle_busy", 32'(busy), 0);
    chk("f1_idle_done", 32'(frame_done), 0);
    cyc();

    // 3x3 with dst_ready toggling; a busy start (thr 99) must be ignored.
    exp_done.push_back(8'd33);
    start(3, 3, 33);
    idx = 0;
    cnt = 0;
    while (idx < 9 && cnt < 40) begin
      dr = (cnt % 2 == 0);
      drv(1'b1, pix(2, idx), dr, dr);
      cfg_start = (cnt == 3);
      if (cnt == 3) begin
        cfg_width     = 11'd1;
        cfg_height    = 11'd1;
        cfg_threshold = 8'd99;
      end
      if (dr) exp_pix.push_back(pix(2, idx));
      mid();
      chk("bp_src_ready", 32'(bus.src_ready), 32'(dr));
      chk("bp_thr", 32'(threshold), 33);
      cyc();
      if (dr) idx++;
      cnt++;
    end
    cfg_start = 1'b0;
    chk("bp_px_count", 32'(idx), 9);
    drv(1'b1, pix(2, 9), 1'b1, 1'b0);
    mid();
    chk("bp_10th_ready", 32'(bus.src_ready), 0);
    cyc();
    drv(1'b0, '0, 1'b0, 1'b0);
    mid();
    chk("bp_done", 32'(frame_done), 1);
    chk("bp_done_thr", 32'(threshold), 33);
    cyc();
    mid();
    chk("bp_idle", 32'(busy), 0);
    cyc();

    // Zero-size start: cfg_err pulse, no frame.
    cfg_start     = 1'b1;
    cfg_width     = 11'd0;
    cfg_height    = 11'd5;
    cfg_threshold = 8'd77;
    cyc();
    cfg_start = 1'b0;
    mid();
    chk("zs_cfg_err", 32'(cfg_err), 1);
    chk("zs_busy", 32'(busy), 0);
    chk("zs_thr", 32'(threshold), 33);
    cyc();
    mid();
    chk("zs_cfg_err_off", 32'(cfg_err), 0);
    chk("zs_busy2", 32'(busy), 0);
    cyc();

    // 2x2 frame whose outputs all arrive during DRAIN, last one completing.
    exp_done.push_back(8'd5);
    start(2, 2, 5);
    feed(3, 4, 0, 5);
    mpat = 6'b010111;
    for (int k = 0; k < 6; k++) begin
      drv(1'b0, '0, 1'b1, mpat[k]);
      mid();
      chk("dr_busy", 32'(busy), 1);
      chk("dr_no_done", 32'(frame_done), 0);
      cyc();
    end
    drv(1'b0, '0, 1'b0, 1'b0);
    mid();
    chk("dr_done", 32'(frame_done), 1);
    cyc();
    mid();
    chk("dr_idle", 32'(busy), 0);
    cyc();

    // Reset after 3 of 8 pixels aborts the frame.
    start(4, 2, 120);
    feed(4, 3, 3, 120);
    rst_n = 1'b0;
    drv(1'b1, pix(4, 3), 1'b1, 1'b1);
    mid();
    chk("rst_mid_src_ready", 32'(bus.src_ready), 0);
    chk("rst_mid_dst_valid", 32'(bus.dst_valid), 0);
    cyc();
    rst_n = 1'b1;
    drv(1'b0, '0, 1'b0, 1'b0);
    mid();
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_thr", 32'(threshold), 0);
    chk("rst_mid_done", 32'(frame_done), 0);
    cyc();
    mid();
    chk("rst_mid_done2", 32'(frame_done), 0);
    cyc();

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
    // Watchdog: 3 of 4 outputs, then DRAIN stalls for 16 cycles.
    start(2, 2, 44);
    feed(5, 4, 3, 44);
    drv(1'b0, '0, 1'b0, 1'b0);
    cnt = 0;
    mid();
    while (!timeout_err && cnt < 40) begin
      chk("wd_busy", 32'(busy), 1);
      cyc();
      cnt++;
      mid();
    end
    chk("wd_cycles", 32'(cnt), 16);
    chk("wd_err", 32'(timeout_err), 1);
    chk("wd_idle", 32'(busy), 0);
    chk("wd_no_done", 32'(frame_done), 0);
    cyc();
    mid();
    chk("wd_sticky", 32'(timeout_err), 1);
    cyc();
`endif

    // 1x1 frame: single pixel is both first and last.
    exp_done.push_back(8'd9);
    start(1, 1, 9);
    mid();
    chk("f5_to_err_clr", 32'(timeout_err), 0);
    cyc();
    feed(6, 1, 1, 9);
    drv(1'b0, '0, 1'b0, 1'b0);
    mid();
    chk("f5_drain_busy", 32'(busy), 1);
    chk("f5_drain_done", 32'(frame_done), 0);
    cyc();
    mid();
    chk("f5_done", 32'(frame_done), 1);
    cyc();
    mid();
    chk("f5_idle", 32'(busy), 0);
    cyc();

    chk("pix_queue_empty", 32'(exp_pix.size()), 0);
    chk("done_queue_empty", 32'(exp_done.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
